// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: AXI4-Lite response codes and responder FSM state types.
package axi4lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
endpackage

// File: rtl/axi4lite_word_ram.sv
// axi4lite_word_ram: word array with byte enables, sync write, registered read-before-write.
module axi4lite_word_ram #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic [DW/8-1:0] we_i,
  input  logic [IW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            re_i,
  input  logic [IW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++)
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_ocm_responder.sv
// axi_ocm_responder: AXI4-Lite slave scratch memory, independent read/write channels,
// one outstanding transaction per direction.
module axi_ocm_responder
  import axi4lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int DEPTH          = 256
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RVALID,
  input  logic                        RREADY
);
  localparam int IW = $clog2(DEPTH);
  logic ready_en_q, aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, waddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, ram_rdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d, ram_we;
  logic [1:0] bresp_q, rresp_q;
  wstate_e wstate_q;
  rstate_e rstate_q;
  logic live, aw_hs, w_hs, ar_hs, wr_fire, w_oor, r_oor, unused_bits;
  // Outputs are forced low combinationally so they read 0 from the first reset cycle.
  assign live    = ~ARESET;
  assign AWREADY = live & ready_en_q & ~aw_held_q & ~bvalid_q;
  assign WREADY  = live & ready_en_q & ~w_held_q & ~bvalid_q;
  assign ARREADY = live & ready_en_q & ~rvalid_q;
  assign BVALID  = live & bvalid_q;
  assign BRESP   = live ? bresp_q : RESP_OKAY;
  assign RVALID  = live & rvalid_q;
  assign RRESP   = live ? rresp_q : RESP_OKAY;
  assign RDATA   = (RVALID && rresp_q == RESP_OKAY) ? ram_rdata : '0;
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign ar_hs   = ARVALID & ARREADY;
  assign waddr_d = aw_held_q ? awaddr_q : AWADDR;
  assign wdata_d = w_held_q ? wdata_q : WDATA;
  assign wstrb_d = w_held_q ? wstrb_q : WSTRB;
  assign wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs) & live;
  assign w_oor   = |waddr_d[AXI_ADDR_WIDTH-1:IW+2];
  assign r_oor   = |ARADDR[AXI_ADDR_WIDTH-1:IW+2];
  assign ram_we  = (wr_fire && !w_oor) ? wstrb_d : '0;
  assign unused_bits = ^{waddr_d[1:0], ARADDR[1:0]};
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wstate_q   <= W_IDLE;
    end else begin
      ready_en_q <= 1'b1;
      if (aw_hs) awaddr_q <= AWADDR;
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (wstate_q == W_IDLE) begin
        if (wr_fire) begin
          aw_held_q <= 1'b0;
          w_held_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= w_oor ? RESP_SLVERR : RESP_OKAY;
          wstate_q  <= W_RESP;
        end else begin
          if (aw_hs) aw_held_q <= 1'b1;
          if (w_hs) w_held_q <= 1'b1;
        end
      end else if (BREADY) begin
        bvalid_q <= 1'b0;
        wstate_q <= W_IDLE;
      end
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rstate_q <= R_IDLE;
    end else if (rstate_q == R_IDLE) begin
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= r_oor ? RESP_SLVERR : RESP_OKAY;
        rstate_q <= R_DATA;
      end
    end else if (RREADY) begin
      rvalid_q <= 1'b0;
      rstate_q <= R_IDLE;
    end
  end
  axi4lite_word_ram #(.DEPTH(DEPTH), .DW(AXI_DATA_WIDTH)) u_ram (
    .clk     (ACLK),
    .we_i    (ram_we),
    .waddr_i (waddr_d[IW+1:2]),
    .wdata_i (wdata_d),
    .re_i    (ar_hs & ~r_oor),
    .raddr_i (ARADDR[IW+1:2]),
    .rdata_o (ram_rdata)
  );
endmodule

// File: tb/tb_axi_ocm_responder.sv
// tb_axi_ocm_responder: directed AXI4-Lite transactions with hand-computed expectations.
module tb_axi_ocm_responder;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, RDATA;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  int n_chk = 0, n_fail = 0;
  logic [31:0] d;
  logic [1:0]  r, br;

  always #5 ACLK = ~ACLK;

  axi_ocm_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge ACLK);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, '0);
    chk({tag, "_rdata"}, RDATA, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                    output logic [1:0] resp);
    int t;
    logic aw_go, w_go;
    AWADDR = a; WDATA = dat; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    t = 0;
    while ((AWVALID || WVALID) && t < 20) begin
      aw_go = AWVALID && AWREADY;
      w_go  = WVALID && WREADY;
      step();
      if (aw_go) AWVALID = 1'b0;
      if (w_go) WVALID = 1'b0;
      t++;
    end
    t = 0;
    while (!BVALID && t < 20) begin
      step();
      t++;
    end
    chk("b_wait", BVALID, 1);
    resp = BRESP;
    AWVALID = 1'b0; WVALID = 1'b0;
    step();
    BREADY = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int t;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    t = 0;
    while (!ARREADY && t < 20) begin
      step();
      t++;
    end
    step();
    ARVALID = 1'b0;
    t = 0;
    while (!RVALID && t < 20) begin
      step();
      t++;
    end
    chk("r_wait", RVALID, 1);
    dat = RDATA;
    resp = RRESP;
    step();
    RREADY = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) step();
    all_zero("in_reset");
    ARESET = 1'b0;
    #1;
    all_zero("first_post_reset");
    step();
    chk("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

    // 1: full-word write and read-back
    wr(32'h000, 32'hDEADBEEF, 4'hF, br);
    chk("t1_bresp", br, 2'b00);
    rd(32'h000, d, r);
    chk("t1_rresp", r, 2'b00);
    chk("t1_rdata", d, 32'hDEADBEEF);

    // 2: single byte lane
    wr(32'h000, 32'h0000AA00, 4'b0010, br);
    chk("t2_bresp", br, 2'b00);
    rd(32'h003, d, r);
    chk("t2_rdata", d, 32'hDEADAAEF);

    // 3: W three cycles ahead of AW
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    chk("t3_wready_first", WREADY, 1);
    step();
    WVALID = 1'b0;
    chk("t3_w_held", {WREADY, AWREADY, BVALID}, 3'b010);
    step();
    step();
    chk("t3_no_early_b", BVALID, 0);
    AWADDR = 32'h010; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("t3_b_latency", BVALID, 1);
    chk("t3_bresp", BRESP, 2'b00);
    step();
    chk("t3_single_b", BVALID, 0);
    step();
    chk("t3_still_single_b", BVALID, 0);
    BREADY = 1'b0;
    rd(32'h010, d, r);
    chk("t3_rdata", d, 32'h12345678);

    // 4: out-of-range address must not alias word 0
    wr(32'h400, 32'hFFFFFFFF, 4'hF, br);
    chk("t4_bresp", br, 2'b10);
    rd(32'h400, d, r);
    chk("t4_rresp", r, 2'b10);
    chk("t4_rdata", d, 32'h0);
    rd(32'h000, d, r);
    chk("t4_word0_unchanged", d, 32'hDEADAAEF);

    // 5: backpressure on B and R
    AWADDR = 32'h020; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      AWVALID = 1'b1; WVALID = 1'b1;
      chk("t5_b_stall", {BVALID, BRESP, AWREADY, WREADY}, 5'b1_00_00);
      step();
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    BREADY = 1'b1;
    step();
    chk("t5_b_done", BVALID, 0);
    BREADY = 1'b0;
    ARADDR = 32'h010; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_r_stall", {RVALID, RRESP, ARREADY}, 4'b1_00_0);
      chk("t5_r_data", RDATA, 32'h12345678);
      step();
    end
    RREADY = 1'b1;
    step();
    chk("t5_r_done", {RVALID, ARREADY}, 2'b01);
    RREADY = 1'b0;
    rd(32'h020, d, r);
    chk("t5_rdata", d, 32'hCAFEF00D);

    // 6: reset with AW held, then a lone W must wait for a fresh AW
    AWADDR = 32'h020; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("t6_aw_held", {AWREADY, WREADY}, 2'b01);
    ARESET = 1'b1;
    #1;
    all_zero("t6_reset_now");
    step();
    step();
    ARESET = 1'b0;
    #1;
    all_zero("t6_first_post_reset");
    step();
    WDATA = 32'h11111111; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    step();
    WVALID = 1'b0;
    step();
    step();
    chk("t6_no_b", BVALID, 0);
    AWADDR = 32'h030; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("t6_b_after_aw", {BVALID, BRESP}, 3'b1_00);
    step();
    BREADY = 1'b0;
    rd(32'h020, d, r);
    chk("t6_old_value", d, 32'hCAFEF00D);
    rd(32'h030, d, r);
    chk("t6_new_word", d, 32'h11111111);

    // 7: same-edge read and write to one word returns pre-write data
    chk("t7_all_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    AWADDR = 32'h000; WDATA = 32'h55555555; WSTRB = 4'hF; ARADDR = 32'h000;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("t7_both_valid", {BVALID, RVALID}, 2'b11);
    chk("t7_pre_write", RDATA, 32'hDEADAAEF);
    step();
    BREADY = 1'b0; RREADY = 1'b0;
    rd(32'h000, d, r);
    chk("t7_post_write", d, 32'h55555555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
